// File: rtl/reg_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_timeout
// Purpose  : Round-robin arbiter that shares one register-bus target between
//            NoPorts requesters. A per-transaction watchdog aborts a stalled
//            transfer with an error response and releases the bus.
// Ports    : clk_i, rst_i        - clock, async active-high reset
//            in_req_i / in_rsp_o - requester-side register bus (NoPorts)
//            out_req_o/out_rsp_i - shared target register bus
//            grant_idx_o         - current grant (meaningful while busy_o)
//            busy_o              - a transaction is in flight
//            timeout_o           - one-cycle pulse on a watchdog abort
//            timeout_count_o     - saturating count of aborts since reset
// Revision : 1.0 - initial release
// ============================================================================

package reg_arb_timeout_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_t;

endpackage

module reg_arb_timeout #(
  parameter int unsigned NoPorts       = 4,
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         req_t         = reg_arb_timeout_pkg::req_t,
  parameter type         rsp_t         = reg_arb_timeout_pkg::rsp_t
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  req_t [NoPorts-1:0]                             in_req_i,
  output rsp_t [NoPorts-1:0]                             in_rsp_o,
  output req_t                                           out_req_o,
  input  rsp_t                                           out_rsp_i,
  output logic [((NoPorts > 1) ? $clog2(NoPorts) : 1)-1:0] grant_idx_o,
  output logic                                           busy_o,
  output logic                                           timeout_o,
  output logic [15:0]                                    timeout_count_o
);

  localparam int unsigned c_GNT_W = (NoPorts > 1) ? $clog2(NoPorts) : 1;
  localparam int unsigned c_WD_W  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  localparam logic [c_GNT_W-1:0] c_LAST_PORT = c_GNT_W'(NoPorts - 1);
  localparam logic [c_WD_W-1:0]  c_WD_LIMIT  = c_WD_W'(TimeoutCycles);

  localparam req_t c_REQ_IDLE = '{
    addr:  {AW{1'b0}},
    write: 1'b0,
    wdata: {DW{1'b0}},
    wstrb: {(DW/8){1'b0}},
    valid: 1'b0
  };
  localparam rsp_t c_RSP_IDLE  = '{rdata: {DW{1'b0}}, error: 1'b0, ready: 1'b0};
  localparam rsp_t c_RSP_ABORT = '{rdata: {DW{1'b0}}, error: 1'b1, ready: 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e               state_q,         state_d;
  logic [c_GNT_W-1:0]   rr_ptr_q,        rr_ptr_d;
  logic [c_GNT_W-1:0]   grant_q,         grant_d;
  logic [c_WD_W-1:0]    wd_cnt_q,        wd_cnt_d;
  logic [15:0]          timeout_cnt_q,   timeout_cnt_d;

  logic                 w_pick_found;
  logic [c_GNT_W-1:0]   w_pick_idx;
  req_t                 w_gnt_req;
  logic                 w_gnt_valid;
  logic                 w_wd_expired;
  logic                 w_timeout;
  logic [c_GNT_W-1:0]   w_next_ptr;

  // Round-robin pick. The first pass finds the lowest valid index overall
  // (the wrap-around candidate); the second pass overrides it with the lowest
  // valid index at or above rr_ptr_q, which has priority when it exists.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = int'(NoPorts) - 1; k >= 0; k--) begin
      if (in_req_i[k].valid) begin
        w_pick_found = 1'b1;
        w_pick_idx   = c_GNT_W'(k);
      end
    end
    for (int k = int'(NoPorts) - 1; k >= 0; k--) begin
      if (in_req_i[k].valid && (c_GNT_W'(k) >= rr_ptr_q)) begin
        w_pick_idx = c_GNT_W'(k);
      end
    end
  end

  assign w_gnt_req    = in_req_i[grant_q];
  assign w_gnt_valid  = w_gnt_req.valid;
  assign w_next_ptr   = (grant_q == c_LAST_PORT) ? '0 : grant_q + c_GNT_W'(1);

  // A target that answers in the expiry cycle still wins over the watchdog.
  assign w_wd_expired = (TimeoutCycles != 0) && (wd_cnt_q == c_WD_LIMIT);
  assign w_timeout    = (state_q == ST_BUSY) && w_gnt_valid &&
                        !out_rsp_i.ready && w_wd_expired;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pick_found) begin
          grant_d  = w_pick_idx;
          wd_cnt_d = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Completion, abort and a requester withdrawing valid all release
        // the bus and advance the pointer past the granted port.
        if (!w_gnt_valid || out_rsp_i.ready || w_timeout) begin
          state_d  = ST_IDLE;
          rr_ptr_d = w_next_ptr;
        end else if (TimeoutCycles != 0) begin
          wd_cnt_d = wd_cnt_q + c_WD_W'(1);
        end
        if (w_timeout && (timeout_cnt_q != 16'hFFFF)) begin
          timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      wd_cnt_q      <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  // Bus steering is combinational so a zero-wait target completes in the
  // first BUSY cycle.
  always_comb begin
    out_req_o = c_REQ_IDLE;
    timeout_o = 1'b0;
    for (int p = 0; p < int'(NoPorts); p++) begin
      in_rsp_o[p] = c_RSP_IDLE;
    end
    if (state_q == ST_BUSY) begin
      if (w_timeout) begin
        in_rsp_o[grant_q] = c_RSP_ABORT;
        timeout_o         = 1'b1;
      end else begin
        out_req_o = w_gnt_req;
        if (w_gnt_valid) begin
          in_rsp_o[grant_q] = out_rsp_i;
        end
      end
    end
  end

  assign grant_idx_o     = grant_q;
  assign busy_o          = (state_q == ST_BUSY);
  assign timeout_count_o = timeout_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_arb_timeout
// Purpose  : Self-checking bench for reg_arb_timeout. A transaction-level
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_arb_timeout;
  import reg_arb_timeout_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  req_t [3:0]  in_req;
  rsp_t [3:0]  in_rsp;
  req_t        out_req;
  rsp_t        out_rsp;
  logic [1:0]  gidx;
  logic        busy, tmo;
  logic [15:0] tcnt;

  // Second instance: two ports, watchdog disabled.
  req_t [1:0]  b_req;
  rsp_t [1:0]  b_in_rsp;
  req_t        b_out_req;
  rsp_t        b_rsp;
  logic [0:0]  b_gidx;
  logic        b_busy, b_tmo;
  logic [15:0] b_tcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_arb_timeout #(.NoPorts(N), .AW(32), .DW(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .in_req_i(in_req), .in_rsp_o(in_rsp),
    .out_req_o(out_req), .out_rsp_i(out_rsp), .grant_idx_o(gidx),
    .busy_o(busy), .timeout_o(tmo), .timeout_count_o(tcnt)
  );

  reg_arb_timeout #(.NoPorts(2), .AW(32), .DW(32), .TimeoutCycles(0)) dut_nowd (
    .clk_i(clk), .rst_i(rst), .in_req_i(b_req), .in_rsp_o(b_in_rsp),
    .out_req_o(b_out_req), .out_rsp_i(b_rsp), .grant_idx_o(b_gidx),
    .busy_o(b_busy), .timeout_o(b_tmo), .timeout_count_o(b_tcnt)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic [31:0] a, input logic w,
                                  input logic [31:0] d, input logic [3:0] s);
    mk_req = '{addr: a, write: w, wdata: d, wstrb: s, valid: 1'b1};
  endfunction

  // ---------------- transaction-level model ----------------
  bit m_busy;
  int m_g, m_ptr, m_age, m_cnt;

  req_t       e_req;
  rsp_t [3:0] e_rsp;
  bit         e_tmo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_g = 0; m_ptr = 0; m_age = 0; m_cnt = 0;
    end else if (m_busy) begin
      if (!in_req[m_g].valid || out_rsp.ready || m_age == TO) begin
        if (in_req[m_g].valid && !out_rsp.ready)
          m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        m_busy = 0;
        m_ptr  = (m_g + 1) % N;
      end else begin
        m_age++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && in_req[(m_ptr + k) % N].valid) begin
          m_busy = 1;
          m_g    = (m_ptr + k) % N;
          m_age  = 0;
        end
      end
    end
  end

  function automatic void model_out();
    req_t r;
    e_req = '0;
    e_rsp = '0;
    e_tmo = 0;
    if (m_busy) begin
      r = in_req[m_g];
      if (r.valid && !out_rsp.ready && m_age == TO) begin
        e_rsp[m_g].ready = 1'b1;
        e_rsp[m_g].error = 1'b1;
        e_tmo = 1;
      end else begin
        e_req = r;
        if (r.valid) e_rsp[m_g] = out_rsp;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      model_out();
      chk("cmp_out_req", 256'(out_req), 256'(e_req));
      chk("cmp_in_rsp",  256'(in_rsp),  256'(e_rsp));
      chk("cmp_busy",    256'(busy),    256'(m_busy));
      chk("cmp_timeout", 256'(tmo),     256'(e_tmo));
      chk("cmp_tcount",  256'(tcnt),    256'(m_cnt[15:0]));
      chk("cmp_grant",   256'(gidx),    256'(m_g[1:0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench stopped by time limit");
  end

  int grants[8];
  int bcyc[8];
  int ng;
  int rdy_cnt[4];
  int pulses;
  bit stall_ok;

  initial begin
    rst     = 1'b1;
    in_req  = '0;
    b_req   = '0;
    b_rsp   = '0;
    in_req[1] = mk_req(32'h44, 1'b1, 32'h1, 4'h1);
    out_rsp = '{rdata: 32'hFFFF_FFFF, error: 1'b1, ready: 1'b1};
    #2;
    chk("reset_busy",    256'(busy),    256'(0));
    chk("reset_grant",   256'(gidx),    256'(0));
    chk("reset_out_req", 256'(out_req), 256'(0));
    chk("reset_in_rsp",  256'(in_rsp),  256'(0));
    chk("reset_tmo",     256'(tmo),     256'(0));
    chk("reset_tcnt",    256'(tcnt),    256'(0));
    in_req  = '0;
    out_rsp = '0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // T1: write on port 2, target ready after three stall cycles
    cyc();
    in_req[2] = mk_req(32'h40, 1'b1, 32'hCAFE0001, 4'hF);
    #2 chk("t1_c0_out_valid", 256'(out_req.valid), 256'(0));
    cyc(); #2;
    chk("t1_c1_busy",    256'(busy), 256'(1));
    chk("t1_c1_grant",   256'(gidx), 256'(2));
    chk("t1_c1_out_req", 256'(out_req), 256'({32'h40, 1'b1, 32'hCAFE0001, 4'hF, 1'b1}));
    chk("t1_c1_ready",   256'(in_rsp[2].ready), 256'(0));
    cyc(); cyc();
    cyc();
    out_rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    #2;
    chk("t1_c4_ready",     256'(in_rsp[2].ready), 256'(1));
    chk("t1_c4_out_valid", 256'(out_req.valid),   256'(1));
    chk("t1_c4_tmo",       256'(tmo),             256'(0));
    cyc();
    in_req[2] = '0;
    out_rsp   = '0;
    #2;
    chk("t1_c5_busy", 256'(busy), 256'(0));
    chk("t1_c5_tcnt", 256'(tcnt), 256'(0));

    // Reset between tests so round-robin restarts at port 0
    #1 rst = 1'b1;
    cyc();
    #2 rst = 1'b0;

    // T2: all ports valid, zero-wait target
    cyc();
    for (int i = 0; i < 4; i++) in_req[i] = mk_req(32'h100 * (i + 1), 1'b0, 32'h0, 4'h0);
    out_rsp = '{rdata: 32'hA5A50000, error: 1'b0, ready: 1'b1};
    #2;
    ng = 0;
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy && ng < 8) begin
        grants[ng] = int'(gidx);
        bcyc[ng]   = c;
        ng++;
      end
      for (int i = 0; i < 4; i++) if (in_rsp[i].ready) rdy_cnt[i]++;
      cyc(); #2;
    end
    in_req  = '0;
    out_rsp = '0;
    chk("t2_ngrants", 256'(ng), 256'(5));
    chk("t2_grant0", 256'(grants[0]), 256'(0));
    chk("t2_grant1", 256'(grants[1]), 256'(1));
    chk("t2_grant2", 256'(grants[2]), 256'(2));
    chk("t2_grant3", 256'(grants[3]), 256'(3));
    chk("t2_grant4", 256'(grants[4]), 256'(0));
    for (int k = 0; k < 5; k++) chk("t2_grant_cycle", 256'(bcyc[k]), 256'(1 + 2 * k));
    chk("t2_ready_p0", 256'(rdy_cnt[0]), 256'(2));
    chk("t2_ready_p1", 256'(rdy_cnt[1]), 256'(1));
    chk("t2_ready_p2", 256'(rdy_cnt[2]), 256'(1));
    chk("t2_ready_p3", 256'(rdy_cnt[3]), 256'(1));

    // T3: port 1 read, target never ready -> abort in BUSY cycle 9
    cyc();
    in_req[1] = mk_req(32'h80, 1'b0, 32'h0, 4'h0);
    in_req[2] = mk_req(32'hC0, 1'b1, 32'h22, 4'h3);
    #2;
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      cyc(); #2;
      if (tmo) pulses++;
    end
    chk("t3_c9_rsp",       256'(in_rsp[1]),     256'({32'h0, 1'b1, 1'b1}));
    chk("t3_c9_out_valid", 256'(out_req.valid), 256'(0));
    chk("t3_c9_tcnt",      256'(tcnt),          256'(0));
    cyc();
    in_req[1] = '0;
    #2;
    if (tmo) pulses++;
    chk("t3_c10_tcnt", 256'(tcnt), 256'(1));
    chk("t3_c10_busy", 256'(busy), 256'(0));
    cyc(); #2;
    if (tmo) pulses++;
    chk("t3_c11_grant", 256'(gidx), 256'(2));
    chk("t3_pulses", 256'(pulses), 256'(1));
    out_rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    cyc();
    in_req[2] = '0;
    out_rsp   = '0;

    // T4: ready arrives exactly when the watchdog would expire
    cyc();
    in_req[3] = mk_req(32'h1F0, 1'b0, 32'h0, 4'h0);
    for (int c = 1; c <= 8; c++) cyc();
    cyc();
    out_rsp = '{rdata: 32'h12345678, error: 1'b0, ready: 1'b1};
    #2;
    chk("t4_c9_rsp", 256'(in_rsp[3]), 256'({32'h12345678, 1'b0, 1'b1}));
    chk("t4_c9_tmo", 256'(tmo),       256'(0));
    cyc();
    in_req[3] = '0;
    out_rsp   = '0;
    #2;
    chk("t4_tcnt_unchanged", 256'(tcnt), 256'(1));

    // T5: error response forwarded only to the granted port
    cyc();
    in_req[0] = mk_req(32'h10, 1'b1, 32'h55AA55AA, 4'hF);
    in_req[1] = mk_req(32'h14, 1'b0, 32'h0, 4'h0);
    cyc();
    out_rsp = '{rdata: 32'hDEAD, error: 1'b1, ready: 1'b1};
    #2;
    chk("t5_grant",   256'(gidx),      256'(0));
    chk("t5_rsp_p0",  256'(in_rsp[0]), 256'({32'hDEAD, 1'b1, 1'b1}));
    chk("t5_rsp_p1",  256'(in_rsp[1]), 256'(0));
    cyc();
    in_req[0] = '0;
    out_rsp   = '0;
    cyc(); #2;
    chk("t5_grant_p1", 256'(gidx), 256'(1));
    // Requester withdraws valid mid-transaction
    cyc();
    in_req[1].valid = 1'b0;
    #2;
    chk("t5_drop_out_valid", 256'(out_req.valid),   256'(0));
    chk("t5_drop_ready",     256'(in_rsp[1].ready), 256'(0));
    cyc();
    in_req[1] = '0;
    #2;
    chk("t5_drop_idle", 256'(busy), 256'(0));
    chk("t5_drop_tcnt", 256'(tcnt), 256'(1));

    // T6: asynchronous reset in the middle of a BUSY transaction
    cyc();
    in_req[2] = mk_req(32'h200, 1'b0, 32'h0, 4'h0);
    cyc(); cyc();
    #2;
    out_rsp = '{rdata: 32'h77, error: 1'b1, ready: 1'b1};
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",    256'(busy),    256'(0));
    chk("t6_rst_grant",   256'(gidx),    256'(0));
    chk("t6_rst_out_req", 256'(out_req), 256'(0));
    chk("t6_rst_in_rsp",  256'(in_rsp),  256'(0));
    chk("t6_rst_tcnt",    256'(tcnt),    256'(0));
    cyc(); cyc();
    #2;
    in_req    = '0;
    out_rsp   = '0;
    in_req[0] = mk_req(32'h300, 1'b0, 32'h0, 4'h0);
    in_req[3] = mk_req(32'h30C, 1'b0, 32'h0, 4'h0);
    rst = 1'b0;
    cyc(); #2;
    chk("t6_post_grant", 256'(gidx), 256'(0));
    out_rsp = '{rdata: 32'h1, error: 1'b0, ready: 1'b1};
    cyc();
    in_req  = '0;
    out_rsp = '0;

    // T7: watchdog disabled, target stalls for 1000 cycles
    cyc();
    b_req[1] = mk_req(32'h400, 1'b0, 32'h0, 4'h0);
    cyc(); #2;
    chk("t7_busy",  256'(b_busy), 256'(1));
    chk("t7_grant", 256'(b_gidx), 256'(1));
    stall_ok = 1;
    repeat (1000) begin
      cyc(); #2;
      if (!b_busy || b_tmo || b_in_rsp[1].ready) stall_ok = 0;
    end
    chk("t7_no_abort", 256'(stall_ok), 256'(1));
    cyc();
    b_rsp = '{rdata: 32'h0BADF00D, error: 1'b0, ready: 1'b1};
    #2;
    chk("t7_rsp",  256'(b_in_rsp[1]), 256'({32'h0BADF00D, 1'b0, 1'b1}));
    chk("t7_tcnt", 256'(b_tcnt),      256'(0));
    cyc();
    b_req = '0;
    b_rsp = '0;
    #2;
    chk("t7_idle", 256'(b_busy), 256'(0));

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
